// File: rtl/alu_pkg.sv
// Shared opcodes, state/shift-kind enums and flag bundle for the sequential ALU.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SLT = 6'b101010;
    localparam logic [5:0] OP_SLL = 6'b000000;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    typedef enum logic {IDLE, SHIFT} state_e;

    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_kind_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
        logic err;
    } flags_t;

    function automatic logic is_shift(input logic [5:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter; runs while its counter is non-zero.
module alu_shifter import alu_pkg::*; #(
    parameter int unsigned W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  shift_kind_e            kind,
    input  logic [$clog2(W)-1:0]   amount,
    input  logic [W-1:0]           data,
    output logic                   last,
    output logic [W-1:0]           result,
    output logic                   carry_out
);

    localparam int unsigned SW = $clog2(W);

    logic [W-1:0]  sh_q, sh_d;
    logic [SW-1:0] cnt_q, cnt_d;
    shift_kind_e   kind_q, kind_d;
    logic          co_q, co_d;

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        kind_d = kind_q;
        co_d   = co_q;
        if (load) begin
            sh_d   = data;
            cnt_d  = amount;
            kind_d = kind;
            co_d   = 1'b0;
        end else if (cnt_q != '0) begin
            case (kind_q)
                SH_LL: begin
                    co_d = sh_q[W-1];
                    sh_d = {sh_q[W-2:0], 1'b0};
                end
                SH_RL: begin
                    co_d = sh_q[0];
                    sh_d = {1'b0, sh_q[W-1:1]};
                end
                default: begin
                    co_d = sh_q[0];
                    sh_d = {sh_q[W-1], sh_q[W-1:1]};
                end
            endcase
            cnt_d = cnt_q - SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            kind_q <= SH_LL;
            co_q   <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
            co_q   <= co_d;
        end
    end

    assign last      = (cnt_q == '0);
    assign result    = sh_q;
    assign carry_out = co_q;

endmodule

// File: rtl/alu_seq.sv
// Registered W-bit ALU: single-cycle logic/arith ops, iterative shifts behind start/busy/done.
module alu_seq import alu_pkg::*; #(
    parameter int unsigned W  = 8,
    parameter int unsigned SW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [5:0]   op,
    output logic [W-1:0] r,
    output logic         done,
    output logic         busy,
    output logic         zero,
    output logic         neg,
    output logic         carry,
    output logic         ovf,
    output logic         err
);

    state_e       state_q, state_d;
    logic [W-1:0] r_q, r_d;
    flags_t       flags_q, flags_d;
    logic         done_q, done_d;

    logic         sh_load;
    shift_kind_e  sh_kind;
    logic         sh_last;
    logic [W-1:0] sh_result;
    logic         sh_carry;

    logic [W:0]   sum, diff;
    logic [W-1:0] alu_r;
    flags_t       alu_f;

    alu_shifter #(.W(W)) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .kind      (sh_kind),
        .amount    (b[SW-1:0]),
        .data      (a),
        .last      (sh_last),
        .result    (sh_result),
        .carry_out (sh_carry)
    );

    // W+1-bit add/sub: the top bit is carry-out for ADD and borrow for SUB.
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        alu_r = '0;
        alu_f = '0;
        case (op)
            OP_ADD: begin
                alu_r       = sum[W-1:0];
                alu_f.carry = sum[W];
                alu_f.ovf   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
                alu_r       = diff[W-1:0];
                alu_f.carry = diff[W];
                alu_f.ovf   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_AND: alu_r = a & b;
            OP_OR:  alu_r = a | b;
            OP_XOR: alu_r = a ^ b;
            OP_NOR: alu_r = ~(a | b);
            OP_SLT: alu_r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL, OP_SRL, OP_SRA: alu_r = '0;
            default: alu_f.err = 1'b1;
        endcase
        alu_f.zero = (alu_r == '0);
        alu_f.neg  = alu_r[W-1];
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        sh_load = 1'b0;
        sh_kind = (op == OP_SLL) ? SH_LL : (op == OP_SRL) ? SH_RL : SH_RA;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_shift(op)) begin
                        sh_load = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        r_d     = alu_r;
                        flags_d = alu_f;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (sh_last) begin
                    r_d           = sh_result;
                    flags_d       = '0;
                    flags_d.zero  = (sh_result == '0);
                    flags_d.neg   = sh_result[W-1];
                    flags_d.carry = sh_carry;
                    done_d        = 1'b1;
                    state_d       = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign r     = r_q;
    assign done  = done_q;
    assign busy  = (state_q == SHIFT);
    assign zero  = flags_q.zero;
    assign neg   = flags_q.neg;
    assign carry = flags_q.carry;
    assign ovf   = flags_q.ovf;
    assign err   = flags_q.err;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the lab's combinational 4-bit ALU. It keeps the MIPS funct-style opcodes and adds NOR/SLL/SLT, condition flags, and variable-amount shifts executed iteratively (one bit per cycle) behind a start/busy/done handshake. It sits between the operand/opcode capture logic and the display/result path of the FPGA ALU lab, and scales to any operand width.

## Interface
- `W`, default 8: operand/result width, ≥ 4.
- `SW`, default `$clog2(W)`: shift-amount width, derived; do not override.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request; sampled only in IDLE.
- `a`, input, W: operand A, captured on the start edge.
- `b`, input, W: operand B, captured on the start edge. For shifts, `b[SW-1:0]` is the shift amount.
- `op`, input, 6: opcode, captured on the start edge.
- `r`, output, W: registered result; holds until the next completion.
- `done`, output, 1: one-cycle pulse when `r` and the flags update.
- `busy`, output, 1: high while a shift is in progress.
- `zero`, `neg`, `carry`, `ovf`, `err`, output, 1 each: registered flags, updated together with `r`.

## Operation
- Opcodes:
  - ADD `100000`, SUB `100010`, AND `100100`, OR `100101`, XOR `100110`, NOR `100111` (`~(a|b)`).
  - SLT `101010`: signed `a<b`, result is 1 or 0.
  - SLL `000000`, SRL `000010`, SRA `000011` (shift A by `b[SW-1:0]`).
  - Any other code is illegal.
- Arithmetic is modulo 2^W. Computing ADD/SUB at W+1 bits is sufficient for the carry.
- Flags:
  - `zero` = (`r`==0).
  - `neg` = `r[W-1]`.
  - `carry`: ADD carry-out; SUB borrow (unsigned `a<b`); shifts give the last bit shifted out (0 if amount is 0); all other ops give 0.
  - `ovf`: signed overflow for ADD/SUB only, else 0.
  - `err`: 1 only for an illegal op.
- Illegal op: `r`=0, `zero`=1, `err`=1, `neg`=`carry`=`ovf`=0. Completes with single-cycle timing.
- FSM states:
  - IDLE:
    - `start` with a non-shift op: compute; update `r`/flags; pulse `done`; stay in IDLE.
    - `start` with a shift op: load the shift register from `a`, load the counter from the amount; set `busy`=1; go to SHIFT.
  - SHIFT:
    - counter ≠ 0: shift one bit and decrement.
      - SLL fills with 0.
      - SRL fills with 0.
      - SRA replicates the MSB.
      - Capture the shifted-out bit.
    - counter = 0: move the shift register to `r`; update flags; pulse `done`; clear `busy`; go to IDLE.
- `start` while `busy` is ignored and not queued.
- `start` in the `done` cycle is accepted, giving back-to-back operations.
- Inputs are not required to stay stable after the start edge.

## Timing
- Reset (async assert, any state): state=IDLE; `r`=0; all flags 0; `done`=0; `busy`=0. A shift in progress is aborted with no `done`.
- Non-shift or illegal op, start on edge k: `r`/flags valid and `done`=1 after edge k, for exactly one cycle. `busy` stays 0.
- Shift by n, start on edge k:
  - `busy`=1 after edge k.
  - Result and `done` after edge k+n+1; `busy` falls on the same edge.
  - n=0 gives completion at k+1 with `r`=`a`.
- Maximum latency is W edges, at n=W-1.
- `done` is never high while `busy` is high.

## Structure
- Package `alu_pkg`:
  - opcode localparams (`OP_ADD` … `OP_SRA`, `OP_SLT`, `OP_SLL`);
  - FSM state typedef {IDLE, SHIFT};
  - shift-kind typedef {SH_LL, SH_RL, SH_RA}.
- Sub-module `alu_shifter`, parametrised by W:
  - contains the shift register, counter and shifted-out bit;
  - signals: `load`/`kind`/`amount` in; `last`/`result`/`carry_out` out.
- Top-level `alu_seq` contains the FSM, the combinational ALU datapath, and the flag/result registers.

## Test plan
All cases use W=8.
- Reset: assert `rst_n`=0 mid-SRA with amount 5 → `busy`/`done`/`r`/flags go to 0 immediately; no `done` after release.
- ADD overflow: `a`=0x7F, `b`=0x01 → next cycle `r`=0x80, `neg`=1, `ovf`=1, `carry`=0, `zero`=0, `done` pulse one cycle. Also `a`=0xFF, `b`=0x01 → `r`=0x00, `zero`=1, `carry`=1, `ovf`=0.
- SUB: `a`=0x05, `b`=0x07 → `r`=0xFE, `carry`=1, `neg`=1, `ovf`=0. SLT `a`=0x80, `b`=0x01 → `r`=0x01.
- SRA: `a`=0x90, amount 3 → `busy` for 4 edges, `r`=0xF2, `carry`=0. `start` pulsed during `busy` is ignored (no extra `done`). SLL `a`=0x81, amount 1 → `r`=0x02, `carry`=1, `done` at k+2.
- Shift amount 0: SRL `a`=0x5A, amount 0 → `r`=0x5A, `carry`=0, `done` at k+1.
- Illegal op `111111` → `r`=0x00, `err`=1, `zero`=1. Back-to-back: start NOR `a`=0x0F, `b`=0xF0 in the `done` cycle → `r`=0x00, `zero`=1, `err`=0.
